// File: rtl/div_seq_32_pkg.sv
// Shared definitions for the sequential 32-bit divider.
// FSM encoding, step count and the divide-by-zero quotient.
package div_seq_32_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int          DIV_STEPS  = 32;
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

  // Two's-complement negate when neg is set.
  function automatic logic [31:0] neg32(
    input logic [31:0] v,
    input logic        neg
  );
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_seq_32_sub.sv
// 33-bit trial subtractor used by the restoring divider.
// borrow is set when b > a (difference would be negative).
module sub_33 (
  input  logic [32:0] a,
  input  logic [32:0] b,
  output logic [32:0] difference,
  output logic        borrow
);

  // Extend to 34 bits so the top bit is the borrow out.
  assign {borrow, difference} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/div_seq_32.sv
// Sequential 32-bit restoring divider, one quotient bit per cycle.
// Define DIV_SIGNED_EN to enable signed (DIV) operation via is_signed.
module div_seq_32
  import div_seq_32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        is_signed,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic        zero_q, zero_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] quotient_q, quotient_d;
  logic [31:0] remainder_q, remainder_d;
  logic        flag_q, flag_d;

  logic [31:0] dd_mag, dv_mag;
  logic [32:0] diff;
  logic        borrow;
  logic        unused_bits;

`ifdef DIV_SIGNED_EN
  logic neg_q_q, neg_q_d;
  logic neg_r_q, neg_r_d;

  assign dd_mag = neg32(dividend, is_signed & dividend[31]);
  assign dv_mag = neg32(divisor, is_signed & divisor[31]);
  assign unused_bits = diff[32];
`else
  assign dd_mag = dividend;
  assign dv_mag = divisor;
  assign unused_bits = diff[32] ^ is_signed;
`endif

  sub_33 u_sub (
    .a          ({rem_q, quo_q[31]}),
    .b          ({1'b0, dvs_q}),
    .difference (diff),
    .borrow     (borrow)
  );

  // Next-state, datapath step and registered output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    zero_d      = zero_q;
    busy_d      = (state_q != IDLE);
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    flag_d      = flag_q;
`ifdef DIV_SIGNED_EN
    neg_q_d     = neg_q_q;
    neg_r_d     = neg_r_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          dvs_d  = dv_mag;
          cnt_d  = 5'd0;
          zero_d = (divisor == 32'd0);
`ifdef DIV_SIGNED_EN
          neg_q_d = is_signed & (dividend[31] ^ divisor[31]);
          neg_r_d = is_signed & dividend[31];
`endif
          if (divisor == 32'd0) begin
            quo_d   = DIV_ZERO_Q;
            rem_d   = dividend;
            state_d = DONE;
          end else begin
            quo_d   = dd_mag;
            rem_d   = 32'd0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d = borrow ? {rem_q[30:0], quo_q[31]} : diff[31:0];
        quo_d = {quo_q[30:0], ~borrow};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(DIV_STEPS - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        flag_d  = zero_q;
        state_d = IDLE;
`ifdef DIV_SIGNED_EN
        if (zero_q) begin
          quotient_d  = quo_q;
          remainder_d = rem_q;
        end else begin
          quotient_d  = neg32(quo_q, neg_q_q);
          remainder_d = neg32(rem_q, neg_r_q);
        end
`else
        quotient_d  = quo_q;
        remainder_d = rem_q;
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and output registers with async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 5'd0;
      rem_q       <= 32'd0;
      quo_q       <= 32'd0;
      dvs_q       <= 32'd0;
      zero_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= 32'd0;
      remainder_q <= 32'd0;
      flag_q      <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      zero_q      <= zero_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      flag_q      <= flag_d;
`ifdef DIV_SIGNED_EN
      neg_q_q     <= neg_q_d;
      neg_r_q     <= neg_r_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = flag_q;

endmodule

// File: tb/tb_div_seq_32.sv
// Self-checking bench for div_seq_32 against a behavioural model.
// Directed cases plus randomized operands, gaps and spurious starts.
module tb_div_seq_32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        is_signed = 1'b0;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  div_seq_32 dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .is_signed   (is_signed),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          acc;
    int          due;
    logic [31:0] eq;
    logic [31:0] er;
    logic        ez;
  } op_t;

  op_t         pend[$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_q = '0;
  logic [31:0] last_r = '0;
  logic        last_z = 1'b0;
  int          last_done = -1;
  int          prev_done = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @cyc %0d: got %h expected %h",
               name, cyc, act, exp);
    end
  endtask

  // Reference: plain arithmetic division results.
  function automatic void model(input logic [31:0] a,
                                input logic [31:0] b,
                                input logic s,
                                output logic [31:0] q,
                                output logic [31:0] r,
                                output logic z);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    z  = (b == 0);
    if (b == 0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
`ifdef DIV_SIGNED_EN
      if (s) begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          q = a;
          r = 0;
        end else begin
          q = sa / sb;
          r = sa % sb;
        end
      end
`else
      if (s && (sa == sb + 1)) q = q;
`endif
    end
  endfunction

  // Per-cycle compare of DUT outputs against the model schedule.
  always @(negedge clk) begin
    if (!rst) begin
      logic exp_done, exp_busy;
      exp_done = pend.size() > 0 && pend[0].due == cyc;
      exp_busy = pend.size() > 0 && cyc > pend[0].acc
                 && cyc <= pend[0].due;
      chk("done", 32'(done), 32'(exp_done));
      chk("busy", 32'(busy), 32'(exp_busy));
      if (exp_done) begin
        last_q = pend[0].eq;
        last_r = pend[0].er;
        last_z = pend[0].ez;
        prev_done = last_done;
        last_done = cyc;
        void'(pend.pop_front());
      end
      chk("quotient", quotient, last_q);
      chk("remainder", remainder, last_r);
      chk("div_by_zero", 32'(div_by_zero), 32'(last_z));
    end
  end

  // Drive one start pulse; the model decides if it is accepted.
  task automatic issue(input logic [31:0] a,
                       input logic [31:0] b,
                       input logic s);
    op_t o;
    dividend  = a;
    divisor   = b;
    is_signed = s;
    start     = 1'b1;
    if (pend.size() == 0 || pend[0].due == cyc) begin
      o.acc = cyc + 1;
      o.due = o.acc + ((b == 0) ? 1 : 33);
      model(a, b, s, o.eq, o.er, o.ez);
      pend.push_back(o);
    end
    @(negedge clk);
    start = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    is_signed = $urandom_range(0, 1);
  endtask

  // Wait until the divider can accept (idle or done cycle).
  task automatic wait_idle();
    int n = 0;
    while (pend.size() != 0 && pend[0].due != cyc) begin
      @(negedge clk);
      n++;
      if (n > 100) begin
        failures++;
        $display("FAIL timeout @cyc %0d waiting for done", cyc);
        pend.delete();
        break;
      end
    end
  endtask

  task automatic drain();
    wait_idle();
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic op(input logic [31:0] a,
                    input logic [31:0] b,
                    input logic s);
    wait_idle();
    issue(a, b, s);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    pend.delete();
    last_q = '0;
    last_r = '0;
    last_z = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] mq, mr;
    logic        mz;
    logic [31:0] a, b;
    int          k;

    model(32'd100, 32'd7, 1'b0, mq, mr, mz);
    chk("model_100_7_q", mq, 32'd14);
    chk("model_100_7_r", mr, 32'd2);
    model(32'hDEAD_BEEF, 32'd0, 1'b0, mq, mr, mz);
    chk("model_dbz_q", mq, 32'hFFFF_FFFF);
    chk("model_dbz_r", mr, 32'hDEAD_BEEF);
    chk("model_dbz_z", 32'(mz), 32'd1);
    model(32'd1000, 32'd10, 1'b1, mq, mr, mz);
    chk("model_1000_10_q", mq, 32'd100);
`ifdef DIV_SIGNED_EN
    model(-32'sd7, 32'd2, 1'b1, mq, mr, mz);
    chk("model_m7_2_q", mq, 32'hFFFF_FFFD);
    chk("model_m7_2_r", mr, 32'hFFFF_FFFF);
    model(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, mq, mr, mz);
    chk("model_ovf_q", mq, 32'h8000_0000);
    chk("model_ovf_r", mr, 32'd0);
`else
    model(-32'sd7, 32'd2, 1'b1, mq, mr, mz);
    chk("model_unsigned_q", mq, 32'h7FFF_FFFC);
`endif

    rst = 1'b1;
    repeat (2) @(negedge clk);
    do_reset();

    op(32'd100, 32'd7, 1'b0);
    k = cyc;
    wait_idle();
    chk("latency_100_7", 32'(cyc - k), 32'd33);
    drain();

    op(32'hDEAD_BEEF, 32'd0, 1'b0);
    k = cyc;
    wait_idle();
    chk("latency_dbz", 32'(cyc - k), 32'd1);
    drain();

`ifdef DIV_SIGNED_EN
    op(-32'sd7, 32'd2, 1'b1);
    op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    drain();
`endif

    op(32'd100, 32'd7, 1'b0);
    repeat (5) @(negedge clk);
    issue(32'd5, 32'd1, 1'b0);
    drain();

    op(32'd100, 32'd7, 1'b0);
    repeat (10) @(negedge clk);
    do_reset();
    repeat (3) @(negedge clk);
    op(32'd9, 32'd3, 1'b0);
    drain();

    op(32'd100, 32'd7, 1'b0);
    op(32'd1000, 32'd10, 1'b0);
    drain();
    chk("b2b_spacing", 32'(last_done - prev_done), 32'd34);

    for (int i = 0; i < 150; i++) begin
      a = $urandom;
      k = $urandom_range(0, 9);
      if (k == 0) b = 0;
      else if (k < 4) b = $urandom_range(1, 15);
      else if (k == 4) b = 32'hFFFF_FFFF;
      else b = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      op(a, b, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 30)) @(negedge clk);
        issue($urandom, $urandom, 1'b0);
      end
      if ($urandom_range(0, 1) == 0) begin
        wait_idle();
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

endmodule
